// File: rtl/riscv_divider_param.sv
// -----------------------------------------------------------------------------
// riscv_divider_param
//   Iterative restoring radix-2 integer divider for the RISC-V M extension.
//   Handles DIV/DIVU/REM/REMU and, on RV64, the W-variants, which operate on
//   32 bits and sign-extend the result. Divide-by-zero and signed overflow
//   bypass the iteration and finish in one cycle.
//
// Ports
//   i_riscv_div_clk      clock, rising edge
//   i_riscv_div_rst      asynchronous reset, active low
//   i_riscv_div_start    request pulse, only sampled while idle
//   i_riscv_div_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_riscv_div_word     W-variant select (ignored unless XLEN=64 and WORD_OPS=1)
//   i_riscv_div_kill     flush; aborts any operation in progress
//   i_riscv_div_rs1data  dividend
//   i_riscv_div_rs2data  divisor
//   o_riscv_div_result   registered result, held until the next completion
//   o_riscv_div_valid    one-cycle result-valid pulse
//   o_riscv_div_busy     high while calculating or presenting a result
// -----------------------------------------------------------------------------
module riscv_divider_param #(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            i_riscv_div_clk,
    input  logic            i_riscv_div_rst,
    input  logic            i_riscv_div_start,
    input  logic [1:0]      i_riscv_div_op,
    input  logic            i_riscv_div_word,
    input  logic            i_riscv_div_kill,
    input  logic [XLEN-1:0] i_riscv_div_rs1data,
    input  logic [XLEN-1:0] i_riscv_div_rs2data,
    output logic [XLEN-1:0] o_riscv_div_result,
    output logic            o_riscv_div_valid,
    output logic            o_riscv_div_busy
);

    localparam int              CW      = $clog2(XLEN) + 1;
    localparam bit              WORD_EN = (XLEN == 64) && (WORD_OPS != 0);
    localparam logic [XLEN-1:0] MIN_X   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    // Sign-extend a 32-bit value to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    // W-variants return the low word sign-extended; full-width ops pass through.
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
        return w ? sext32(v[31:0]) : v;
    endfunction

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;      // {remainder, dividend/quotient}
    logic [XLEN-1:0]     r_div;      // divisor magnitude
    logic                r_word;
    logic                r_rem_sel;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_word;
    logic                w_signed;
    logic [XLEN-1:0]     w_a_ext;
    logic [XLEN-1:0]     w_b_ext;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN-1:0]     w_dvd_init;
    logic                w_div_zero;
    logic                w_ovf;
    logic [XLEN-1:0]     w_spec_res;
    logic [XLEN:0]       w_hi_sh;
    logic [XLEN:0]       w_diff;
    logic                w_ge;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]     w_q;
    logic [XLEN-1:0]     w_r;
    logic [XLEN-1:0]     w_calc_res;
    logic                w_last;

    // Request decode: operand extension, magnitudes and special cases.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_word   = WORD_EN ? i_riscv_div_word : 1'b0;
        w_signed = ~i_riscv_div_op[0];
        w_a_ext  = i_riscv_div_rs1data;
        w_b_ext  = i_riscv_div_rs2data;
        if (w_word) begin
            w_a_ext = w_signed ? sext32(i_riscv_div_rs1data[31:0]) : XLEN'(i_riscv_div_rs1data[31:0]);
            w_b_ext = w_signed ? sext32(i_riscv_div_rs2data[31:0]) : XLEN'(i_riscv_div_rs2data[31:0]);
        end
        w_a_neg    = w_signed & w_a_ext[XLEN-1];
        w_b_neg    = w_signed & w_b_ext[XLEN-1];
        w_mag_a    = w_a_neg ? -w_a_ext : w_a_ext;
        w_mag_b    = w_b_neg ? -w_b_ext : w_b_ext;
        // A word dividend is left-aligned so N steps shift it fully into the remainder.
        w_dvd_init = w_word ? (w_mag_a << (XLEN-32)) : w_mag_a;
        w_div_zero = (w_b_ext == '0);
        w_ovf      = w_signed && (w_b_ext == '1) &&
                     (w_a_ext == (w_word ? sext32(32'h8000_0000) : MIN_X));
        w_spec_res = '0;
        if (w_div_zero)
            w_spec_res = i_riscv_div_op[1] ? w_a_ext : '1;
        else
            w_spec_res = i_riscv_div_op[1] ? '0 : w_a_ext;
        w_spec_res = fin(w_spec_res, w_word);
    end

    // One restoring step: shift, trial-subtract on XLEN+1 bits, keep or restore.
    always_comb begin
        w_hi_sh    = r_acc[2*XLEN-1:XLEN-1];
        w_diff     = w_hi_sh - {1'b0, r_div};
        w_ge       = ~w_diff[XLEN];
        w_acc_nxt  = {(w_ge ? w_diff[XLEN-1:0] : w_hi_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
        w_q        = w_acc_nxt[XLEN-1:0];
        w_r        = w_acc_nxt[2*XLEN-1:XLEN];
        if (r_rem_sel)
            w_calc_res = r_neg_r ? -w_r : w_r;
        else
            w_calc_res = r_neg_q ? -w_q : w_q;
        w_calc_res = fin(w_calc_res, r_word);
        w_last     = (r_cnt == (r_word ? CW'(31) : CW'(XLEN-1)));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the datapath registers are reset too, so a post-reset start is identical to power-up.
    always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rst) begin
        if (!i_riscv_div_rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_acc              <= '0;
            r_div              <= '0;
            r_word             <= 1'b0;
            r_rem_sel          <= 1'b0;
            r_neg_q            <= 1'b0;
            r_neg_r            <= 1'b0;
            o_riscv_div_result <= '0;
            o_riscv_div_valid  <= 1'b0;
            o_riscv_div_busy   <= 1'b0;
        end else begin
            o_riscv_div_valid <= 1'b0;
            if (i_riscv_div_kill) begin
                // Result is deliberately left untouched on a flush.
                r_state          <= S_IDLE;
                r_cnt            <= '0;
                o_riscv_div_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_riscv_div_start) begin
                            o_riscv_div_busy <= 1'b1;
                            if (w_div_zero || w_ovf) begin
                                o_riscv_div_result <= w_spec_res;
                                o_riscv_div_valid  <= 1'b1;
                                r_state            <= S_DONE;
                            end else begin
                                r_acc     <= {{XLEN{1'b0}}, w_dvd_init};
                                r_div     <= w_mag_b;
                                r_word    <= w_word;
                                r_rem_sel <= i_riscv_div_op[1];
                                r_neg_q   <= w_a_neg ^ w_b_neg;
                                r_neg_r   <= w_a_neg;
                                r_cnt     <= '0;
                                r_state   <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_acc_nxt;
                        if (w_last) begin
                            r_cnt              <= '0;
                            o_riscv_div_result <= w_calc_res;
                            o_riscv_div_valid  <= 1'b1;
                            r_state            <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        o_riscv_div_busy <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                    default: begin
                        o_riscv_div_busy <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_divider_param.sv
// -----------------------------------------------------------------------------
// tb_riscv_divider_param
//   Directed bench for riscv_divider_param (XLEN=64, WORD_OPS=1): a table of
//   operations with hand-computed results and latencies, followed by
//   hand-written kill, busy-start and mid-operation reset sequences.
// -----------------------------------------------------------------------------
module tb_riscv_divider_param;

    localparam int XLEN = 64;
    localparam int TMO  = 200;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic            word = 1'b0;
    logic            kill = 1'b0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic [XLEN-1:0] result;
    logic            valid;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string           name;
        logic [1:0]      op;
        logic            word;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    vec_t vecs[18];

    riscv_divider_param #(.XLEN(XLEN), .WORD_OPS(1)) dut (
        .i_riscv_div_clk     (clk),
        .i_riscv_div_rst     (rst_n),
        .i_riscv_div_start   (start),
        .i_riscv_div_op      (op),
        .i_riscv_div_word    (word),
        .i_riscv_div_kill    (kill),
        .i_riscv_div_rs1data (rs1),
        .i_riscv_div_rs2data (rs2),
        .o_riscv_div_result  (result),
        .o_riscv_div_valid   (valid),
        .o_riscv_div_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request for exactly one rising edge.
    task automatic launch(input logic [1:0] o, input logic w,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        op    = o;
        word  = w;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // k = number of the cycle after the start edge in which valid is seen.
    task automatic wait_valid(output int k);
        k = 1;
        @(negedge clk);
        while (!valid && k < TMO) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        int pulses;
        int first;

        vecs[0]  = '{"div_neg",      OP_DIV,  1'b0, -64'sd20, 64'd3, -64'sd6, 65};
        vecs[1]  = '{"rem_neg",      OP_REM,  1'b0, -64'sd20, 64'd3, -64'sd2, 65};
        vecs[2]  = '{"divu_big",     OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 65};
        vecs[3]  = '{"remu_big",     OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65};
        vecs[4]  = '{"div_by0",      OP_DIV,  1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[5]  = '{"rem_ovf",      OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[6]  = '{"div_ovf",      OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[7]  = '{"divw_min",     OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
        vecs[8]  = '{"divuw_by0",    OP_DIVU, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[9]  = '{"div_negdiv",   OP_DIV,  1'b0, 64'd20, -64'sd3, -64'sd6, 65};
        vecs[10] = '{"rem_negdiv",   OP_REM,  1'b0, 64'd20, -64'sd3, 64'd2, 65};
        vecs[11] = '{"divu_small",   OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[12] = '{"remu_small",   OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        vecs[13] = '{"remw_neg",     OP_REM,  1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[14] = '{"divw_neg",     OP_DIV,  1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[15] = '{"divuw_top",    OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
        vecs[16] = '{"remuw_by0",    OP_REMU, 1'b1, 64'h0000_0001_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
        vecs[17] = '{"div_not_wovf", OP_DIV,  1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 65};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors: result, latency and single-cycle pulse.
        for (int i = 0; i < 18; i++) begin
            launch(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
            wait_valid(k);
            check({vecs[i].name, "_result"}, result, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 64'(k), 64'(vecs[i].lat));
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, {63'd0, valid}, 64'd0);
        end

        // Start while busy is ignored; operand changes after start do not matter.
        launch(OP_DIV, 1'b0, 64'd1000, 64'd10);
        first  = 0;
        pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (c == 5) begin
                op    = OP_DIVU;
                rs1   = 64'd7;
                rs2   = 64'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_start_latency", 64'(first), 64'd65);
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_result", result, 64'd100);

        // Kill in CALC, with a coincident special-case start that must be dropped.
        launch(OP_DIV, 1'b0, 64'd5000, 64'd7);
        pulses = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (valid) pulses++;
            if (c == 10) begin
                kill  = 1'b1;
                start = 1'b1;
                op    = OP_DIV;
                rs2   = 64'd0;
            end else begin
                kill  = 1'b0;
                start = 1'b0;
            end
        end
        check("kill_pulses", 64'(pulses), 64'd0);
        check("kill_result_held", result, 64'd100);
        check("kill_busy", {63'd0, busy}, 64'd0);
        launch(OP_DIV, 1'b0, 64'd5000, 64'd7);
        wait_valid(k);
        check("after_kill_result", result, 64'd714);
        check("after_kill_latency", 64'(k), 64'd65);

        // Reset in the middle of CALC.
        launch(OP_DIVU, 1'b0, 64'd1000, 64'd3);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_result", result, 64'd0);
        check("midreset_valid", {63'd0, valid}, 64'd0);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("midreset_pulses", 64'(pulses), 64'd0);
        launch(OP_REM, 1'b0, -64'sd7, 64'd2);
        wait_valid(k);
        check("after_reset_result", result, -64'sd1);
        check("after_reset_latency", 64'(k), 64'd65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
